// File: rtl/ps2_scan_rx_pkg.sv
// Shared constants for the PS/2 receive path and the downstream scan-code decoder.
package ps2_scan_rx_pkg;

   // Prefix bytes that modify the meaning of the following byte
   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   // Frame receiver state encodings
   typedef logic [1:0] ps2_state_t;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // A PS/2 frame carries odd parity: data ones plus parity bit is odd
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return (^data) ^ par;
   endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Output bus of the PS/2 receiver towards the scan-code decoder.
//
// Handshake: there is no ready. scan_valid is a one-cycle strobe that marks the
// cycle scan_code was (re)loaded; scan_code stays stable until the next strobe.
// key_release and frame_err are independent one-cycle event strobes. The sink
// must take every strobe in the cycle it is high. state is a debug view of the
// receiver FSM.
interface ps2_scan_rx_if;
   import ps2_scan_rx_pkg::*;

   logic [7:0] scan_code;
   logic       scan_valid;
   logic       key_release;
   logic       frame_err;
   ps2_state_t state;

   modport master (output scan_code, scan_valid, key_release, frame_err, state);
   modport slave  (input  scan_code, scan_valid, key_release, frame_err, state);

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser, saturating glitch filter and falling-edge detector for
// one asynchronous PS/2 line. The line idles high, so everything resets to 1.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN) + 1;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          fall_q,  fall_d;

   // Level flips only after FILTER_LEN consecutive samples disagree with it
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      fall_d = level_q & ~level_d;
   end

   // Synchroniser, filter and edge registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames bytes on filtered ps2_clk falls, checks start,
// odd parity and stop, strips E0/F0 prefixes and presents make codes.
module ps2_scan_rx
   import ps2_scan_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYC    = 100000,
   parameter bit CLEAR_ON_BREAK = 1'b0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            ps2_clk,
   input  logic            ps2_data,
   ps2_scan_rx_if.master   bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic          clk_fall;
   logic          dsync1_q, dsync1_d;
   logic          dsync2_q, dsync2_d;
   ps2_state_t    state_q,  state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q,  shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q,    tmo_d;
   logic          ext_q,    ext_d;
   logic          brk_q,    brk_d;
   logic [7:0]    code_q,   code_d;
   logic          valid_q,  valid_d;
   logic          rel_q,    rel_d;
   logic          err_q,    err_d;
   logic          byte_ok;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (ps2_clk),
      .fall    (clk_fall)
   );

   // Frame FSM, timeout and prefix/byte handling
   always_comb begin
      dsync1_d = ps2_data;
      dsync2_d = dsync1_q;
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      ext_d    = ext_q;
      brk_d    = brk_q;
      code_d   = code_q;
      valid_d  = 1'b0;
      rel_d    = 1'b0;
      err_d    = 1'b0;
      byte_ok  = 1'b0;
      tmo_d    = (state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;

      if (clk_fall) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!dsync2_q) begin
                  state_d  = ST_DATA;
                  bitcnt_d = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d  = {dsync2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = dsync2_q;
               state_d  = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (dsync2_q && odd_parity_ok(shift_q, parity_q)) byte_ok = 1'b1;
               else                                               err_d   = 1'b1;
            end
         endcase
      end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         // Keyboard stalled mid-frame: drop the partial byte, keep prefixes
         state_d = ST_IDLE;
         tmo_d   = '0;
         err_d   = 1'b1;
      end

      if (byte_ok) begin
         if (shift_q == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (shift_q == PS2_BREAK) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            rel_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (CLEAR_ON_BREAK && shift_q == code_q) begin
               code_d  = 8'h00;
               valid_d = 1'b1;
            end
         end else if (ext_q) begin
            ext_d = 1'b0;
         end else begin
            code_d  = shift_q;
            valid_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dsync1_q <= 1'b1;
         dsync2_q <= 1'b1;
         state_q  <= ST_IDLE;
         bitcnt_q <= 3'd0;
         shift_q  <= 8'h00;
         parity_q <= 1'b0;
         tmo_q    <= '0;
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         code_q   <= 8'h00;
         valid_q  <= 1'b0;
         rel_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         dsync1_q <= dsync1_d;
         dsync2_q <= dsync2_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tmo_q    <= tmo_d;
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         rel_q    <= rel_d;
         err_q    <= err_d;
      end
   end

   assign bus.scan_code   = code_q;
   assign bus.scan_valid  = valid_q;
   assign bus.key_release = rel_q;
   assign bus.frame_err   = err_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: two instances share the PS/2 lines, one with
// CLEAR_ON_BREAK=0 and one with CLEAR_ON_BREAK=1; pulses are counted per instance.
module tb_ps2_scan_rx;
  import ps2_scan_rx_pkg::*;

  localparam time HALF = 400ns;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  int checks = 0;
  int errors = 0;
  int v0 = 0, r0 = 0, e0 = 0, v1 = 0, r1 = 0, e1 = 0, ovl = 0;
  int s_v0, s_r0, s_e0, s_v1, s_r1, s_e1;

  ps2_scan_rx_if bus0 ();
  ps2_scan_rx_if bus1 ();

  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(400), .CLEAR_ON_BREAK(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus0));
  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(400), .CLEAR_ON_BREAK(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus1));

  // clock / reset
  always #5ns clk = ~clk;

  // pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus0.scan_valid)  v0++;
    if (bus0.key_release) r0++;
    if (bus0.frame_err)   e0++;
    if (bus1.scan_valid)  v1++;
    if (bus1.key_release) r1++;
    if (bus1.frame_err)   e1++;
    if (bus0.frame_err && (bus0.scan_valid || bus0.key_release)) ovl++;
    if (bus1.frame_err && (bus1.scan_valid || bus1.key_release)) ovl++;
    if (bus0.scan_valid && bus0.key_release) ovl++;
  end

  task automatic snap();
    s_v0 = v0; s_r0 = r0; s_e0 = e0; s_v1 = v1; s_r1 = r1; s_e1 = e1;
  endtask

  // driver: keyboard puts data up while clock is high, receiver samples on the fall
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                            input int nbits, input logic glitch);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      #100ns;
      if (glitch) begin ps2_clk = 1'b0; #20ns; ps2_clk = 1'b1; end
      #80ns;
      ps2_clk = 1'b0;
      #200ns;
      if (glitch) begin ps2_clk = 1'b1; #20ns; ps2_clk = 1'b0; end
      #(HALF - 200ns);
      ps2_clk = 1'b1;
      #200ns;
    end
    ps2_data = 1'b1;
    #2us;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (bus0.scan_code !== 8'h00) begin errors++; $display("FAIL rst_code0 got %h want 00", bus0.scan_code); end
    checks++; if (bus0.scan_valid !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %b want 0", bus0.scan_valid); end
    checks++; if (bus0.key_release !== 1'b0) begin errors++; $display("FAIL rst_rel0 got %b want 0", bus0.key_release); end
    checks++; if (bus0.frame_err !== 1'b0) begin errors++; $display("FAIL rst_err0 got %b want 0", bus0.frame_err); end
    checks++; if (bus0.state !== ST_IDLE) begin errors++; $display("FAIL rst_state0 got %0d want 0", bus0.state); end
    checks++; if (bus1.scan_code !== 8'h00) begin errors++; $display("FAIL rst_code1 got %h want 00", bus1.scan_code); end
    checks++; if (bus1.state !== ST_IDLE) begin errors++; $display("FAIL rst_state1 got %0d want 0", bus1.state); end
    reset_n = 1'b1;
    snap();
    #1us;
    checks++; if (v0 + e0 + r0 - s_v0 - s_e0 - s_r0 !== 0) begin errors++; $display("FAIL rst_quiet got %0d pulses want 0", v0 + e0 + r0 - s_v0 - s_e0 - s_r0); end
  endtask

  task automatic test_single_make();
    snap();
    send_ok(8'h16);
    checks++; if (v0 - s_v0 !== 1) begin errors++; $display("FAIL mk16_valid0 got %0d want 1", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h16) begin errors++; $display("FAIL mk16_code0 got %h want 16", bus0.scan_code); end
    checks++; if (r0 - s_r0 !== 0) begin errors++; $display("FAIL mk16_rel0 got %0d want 0", r0 - s_r0); end
    checks++; if (e0 - s_e0 !== 0) begin errors++; $display("FAIL mk16_err0 got %0d want 0", e0 - s_e0); end
    checks++; if (v1 - s_v1 !== 1) begin errors++; $display("FAIL mk16_valid1 got %0d want 1", v1 - s_v1); end
    checks++; if (bus1.scan_code !== 8'h16) begin errors++; $display("FAIL mk16_code1 got %h want 16", bus1.scan_code); end
  endtask

  task automatic test_break();
    send_ok(8'h1E);
    checks++; if (bus0.scan_code !== 8'h1E) begin errors++; $display("FAIL mk1e_code0 got %h want 1e", bus0.scan_code); end
    snap();
    send_ok(PS2_BREAK);
    checks++; if (v0 + r0 - s_v0 - s_r0 !== 0) begin errors++; $display("FAIL f0_quiet got %0d pulses want 0", v0 + r0 - s_v0 - s_r0); end
    send_ok(8'h1E);
    checks++; if (r0 - s_r0 !== 1) begin errors++; $display("FAIL brk_rel0 got %0d want 1", r0 - s_r0); end
    checks++; if (v0 - s_v0 !== 0) begin errors++; $display("FAIL brk_valid0 got %0d want 0", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h1E) begin errors++; $display("FAIL brk_code0 got %h want 1e", bus0.scan_code); end
    checks++; if (r1 - s_r1 !== 1) begin errors++; $display("FAIL brk_rel1 got %0d want 1", r1 - s_r1); end
    checks++; if (v1 - s_v1 !== 1) begin errors++; $display("FAIL brk_valid1 got %0d want 1", v1 - s_v1); end
    checks++; if (bus1.scan_code !== 8'h00) begin errors++; $display("FAIL brk_code1 got %h want 00", bus1.scan_code); end
    snap();
    send_ok(8'h1E);
    send_ok(8'h1E);
    checks++; if (v0 - s_v0 !== 2) begin errors++; $display("FAIL typ_valid0 got %0d want 2", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h1E) begin errors++; $display("FAIL typ_code0 got %h want 1e", bus0.scan_code); end
    checks++; if (bus1.scan_code !== 8'h1E) begin errors++; $display("FAIL typ_code1 got %h want 1e", bus1.scan_code); end
  endtask

  task automatic test_frame_err();
    snap();
    send_frame(8'h33, 1'b1, 1'b1, 11, 1'b0);
    checks++; if (e0 - s_e0 !== 1) begin errors++; $display("FAIL par_err0 got %0d want 1", e0 - s_e0); end
    checks++; if (v0 - s_v0 !== 0) begin errors++; $display("FAIL par_valid0 got %0d want 0", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h1E) begin errors++; $display("FAIL par_code0 got %h want 1e", bus0.scan_code); end
    checks++; if (e1 - s_e1 !== 1) begin errors++; $display("FAIL par_err1 got %0d want 1", e1 - s_e1); end
    snap();
    send_frame(8'h44, 1'b0, 1'b0, 11, 1'b0);
    checks++; if (e0 - s_e0 !== 1) begin errors++; $display("FAIL stop_err0 got %0d want 1", e0 - s_e0); end
    checks++; if (bus0.scan_code !== 8'h1E) begin errors++; $display("FAIL stop_code0 got %h want 1e", bus0.scan_code); end
    snap();
    ps2_data = 1'b1;
    ps2_clk = 1'b0; #HALF; ps2_clk = 1'b1; #2us;
    checks++; if (e0 - s_e0 !== 1) begin errors++; $display("FAIL start_err0 got %0d want 1", e0 - s_e0); end
    checks++; if (bus0.state !== ST_IDLE) begin errors++; $display("FAIL start_state0 got %0d want 0", bus0.state); end
    snap();
    send_ok(PS2_BREAK);
    send_frame(8'h33, 1'b1, 1'b1, 11, 1'b0);
    send_ok(8'h1E);
    checks++; if (r0 - s_r0 !== 1) begin errors++; $display("FAIL keep_rel0 got %0d want 1", r0 - s_r0); end
    checks++; if (v0 - s_v0 !== 0) begin errors++; $display("FAIL keep_valid0 got %0d want 0", v0 - s_v0); end
    checks++; if (e0 - s_e0 !== 1) begin errors++; $display("FAIL keep_err0 got %0d want 1", e0 - s_e0); end
    checks++; if (bus1.scan_code !== 8'h00) begin errors++; $display("FAIL keep_code1 got %h want 00", bus1.scan_code); end
  endtask

  task automatic test_timeout();
    snap();
    send_frame(8'h55, 1'b0, 1'b1, 4, 1'b0);
    checks++; if (bus0.state !== ST_DATA) begin errors++; $display("FAIL tmo_mid_state0 got %0d want 1", bus0.state); end
    #3us;
    checks++; if (e0 - s_e0 !== 1) begin errors++; $display("FAIL tmo_err0 got %0d want 1", e0 - s_e0); end
    checks++; if (bus0.state !== ST_IDLE) begin errors++; $display("FAIL tmo_state0 got %0d want 0", bus0.state); end
    snap();
    send_ok(8'h26);
    checks++; if (v0 - s_v0 !== 1) begin errors++; $display("FAIL tmo26_valid0 got %0d want 1", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h26) begin errors++; $display("FAIL tmo26_code0 got %h want 26", bus0.scan_code); end
    checks++; if (e0 - s_e0 !== 0) begin errors++; $display("FAIL tmo26_err0 got %0d want 0", e0 - s_e0); end
    checks++; if (bus1.scan_code !== 8'h26) begin errors++; $display("FAIL tmo26_code1 got %h want 26", bus1.scan_code); end
  endtask

  task automatic test_ext();
    snap();
    send_ok(PS2_EXT);
    send_ok(8'h75);
    checks++; if (v0 - s_v0 !== 0) begin errors++; $display("FAIL ext_valid0 got %0d want 0", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h26) begin errors++; $display("FAIL ext_code0 got %h want 26", bus0.scan_code); end
    send_ok(8'h45);
    checks++; if (v0 - s_v0 !== 1) begin errors++; $display("FAIL ext45_valid0 got %0d want 1", v0 - s_v0); end
    checks++; if (bus0.scan_code !== 8'h45) begin errors++; $display("FAIL ext45_code0 got %h want 45", bus0.scan_code); end
    snap();
    send_ok(PS2_EXT);
    send_ok(PS2_BREAK);
    send_ok(8'h75);
    checks++; if (r0 - s_r0 !== 1) begin errors++; $display("FAIL extbrk_rel0 got %0d want 1", r0 - s_r0); end
    checks++; if (v1 - s_v1 !== 0) begin errors++; $display("FAIL extbrk_valid1 got %0d want 0", v1 - s_v1); end
    checks++; if (bus1.scan_code !== 8'h45) begin errors++; $display("FAIL extbrk_code1 got %h want 45", bus1.scan_code); end
  endtask

  task automatic test_glitch();
    snap();
    ps2_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0; #20ns; ps2_clk = 1'b1; #200ns;
    end
    #1us;
    checks++; if (e0 + v0 - s_e0 - s_v0 !== 0) begin errors++; $display("FAIL gl_idle got %0d pulses want 0", e0 + v0 - s_e0 - s_v0); end
    checks++; if (bus0.state !== ST_IDLE) begin errors++; $display("FAIL gl_state0 got %0d want 0", bus0.state); end
    snap();
    send_frame(8'h2E, 1'b0, 1'b1, 11, 1'b1);
    checks++; if (v0 - s_v0 !== 1) begin errors++; $display("FAIL gl2e_valid0 got %0d want 1", v0 - s_v0); end
    checks++; if (e0 - s_e0 !== 0) begin errors++; $display("FAIL gl2e_err0 got %0d want 0", e0 - s_e0); end
    checks++; if (bus0.scan_code !== 8'h2E) begin errors++; $display("FAIL gl2e_code0 got %h want 2e", bus0.scan_code); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h3E, 1'b0, 1'b1, 5, 1'b0);
    reset_n = 1'b0;
    #50ns;
    checks++; if (bus0.scan_code !== 8'h00) begin errors++; $display("FAIL rmf_code0 got %h want 00", bus0.scan_code); end
    checks++; if (bus0.state !== ST_IDLE) begin errors++; $display("FAIL rmf_state0 got %0d want 0", bus0.state); end
    snap();
    reset_n = 1'b1;
    #2us;
    checks++; if (v0 + r0 + e0 - s_v0 - s_r0 - s_e0 !== 0) begin errors++; $display("FAIL rmf_quiet got %0d pulses want 0", v0 + r0 + e0 - s_v0 - s_r0 - s_e0); end
    snap();
    send_ok(8'h3E);
    checks++; if (v0 - s_v0 !== 1) begin errors++; $display("FAIL rmf3e_valid0 got %0d want 1", v0 - s_v0); end
    checks++; if (e0 - s_e0 !== 0) begin errors++; $display("FAIL rmf3e_err0 got %0d want 0", e0 - s_e0); end
    checks++; if (bus0.scan_code !== 8'h3E) begin errors++; $display("FAIL rmf3e_code0 got %h want 3e", bus0.scan_code); end
    checks++; if (bus1.scan_code !== 8'h3E) begin errors++; $display("FAIL rmf3e_code1 got %h want 3e", bus1.scan_code); end
  endtask

  initial begin
    #23ns;
    test_reset();
    test_single_make();
    test_break();
    test_frame_err();
    test_timeout();
    test_ext();
    test_glitch();
    test_reset_mid_frame();
    checks++; if (ovl !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", ovl); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
